// File: rtl/muldiv_hilo_ctrl.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer and HI/LO register owner.
// Fixed-latency multiplier, 32-step restoring divider, MTHI/MTLO writes, flush cancel.
module muldiv_hilo_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_e,
  input  logic        op_mult,
  input  logic        op_multu,
  input  logic        op_div,
  input  logic        op_divu,
  input  logic        op_mthi,
  input  logic        op_mtlo,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        stall_ext,
  input  logic        flush,
  output logic        stall_e,
  output logic        busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_n;
  logic [4:0]  cnt;
  logic [31:0] opa, opb;
  logic [32:0] rem;
  logic        sgn, is_div, nowr, qneg, rneg;

  logic        is_mul_op, is_div_op, start, div_sgn;
  logic [31:0] a_abs, b_abs;
  logic [32:0] rem_sh, rem_sub;
  logic        q_bit;
  logic signed [32:0] ma, mb;
  logic [63:0] prod;
  logic [31:0] lo_div, hi_div;

  assign is_mul_op = op_mult | op_multu;
  assign is_div_op = op_div | op_divu;
  assign start     = valid_e & (is_mul_op | is_div_op) & ~flush;

  assign div_sgn = op_div;
  assign a_abs   = (div_sgn & src_a[31]) ? -src_a : src_a;
  assign b_abs   = (div_sgn & src_b[31]) ? -src_b : src_b;

  // opa doubles as the dividend shifter; quotient bits enter at the LSB
  assign rem_sh  = {rem[31:0], opa[31]};
  assign rem_sub = rem_sh - {1'b0, opb};
  assign q_bit   = (rem_sh >= {1'b0, opb});

  assign ma   = {sgn & opa[31], opa};
  assign mb   = {sgn & opb[31], opb};
  assign prod = 64'(ma) * 64'(mb);

  assign lo_div = qneg ? -opa : opa;
  assign hi_div = rneg ? -rem[31:0] : rem[31:0];

  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    stall_e = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall_e = 1'b1;
          if (is_mul_op)        state_n = (MUL_LAT == 1) ? DONE : MUL;
          else if (src_b == '0) state_n = DONE;
          else                  state_n = DIV;
        end
      end
      MUL, DIV: begin
        stall_e = 1'b1;
        if (cnt == '0) state_n = DONE;
      end
      DONE: begin
        if (!stall_ext) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      stall_e = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      rem    <= '0;
      sgn    <= 1'b0;
      is_div <= 1'b0;
      nowr   <= 1'b0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul_op) begin
              opa    <= src_a;
              opb    <= src_b;
              sgn    <= op_mult;
              is_div <= 1'b0;
              nowr   <= 1'b0;
              cnt    <= 5'(MUL_LAT - 1);
            end else begin
              opa    <= a_abs;
              opb    <= b_abs;
              is_div <= 1'b1;
              nowr   <= (src_b == '0);
              qneg   <= div_sgn & (src_a[31] ^ src_b[31]);
              rneg   <= div_sgn & src_a[31];
              rem    <= '0;
              cnt    <= 5'd31;
            end
          end else if (valid_e && !flush && !stall_ext) begin
            if (op_mthi) hi_o <= src_a;
            if (op_mtlo) lo_o <= src_a;
          end
        end
        MUL: cnt <= cnt - 5'd1;
        DIV: begin
          rem <= q_bit ? rem_sub : rem_sh;
          opa <= {opa[30:0], q_bit};
          cnt <= cnt - 5'd1;
        end
        DONE: begin
          if (!stall_ext && !flush && !nowr) begin
            if (is_div) begin
              hi_o <= hi_div;
              lo_o <= lo_div;
            end else begin
              hi_o <= prod[63:32];
              lo_o <= prod[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Randomized self-checking bench for muldiv_hilo_ctrl against an arithmetic HI/LO model.
module tb_muldiv_hilo_ctrl;
  localparam int MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        resetn, valid_e, stall_ext, flush;
  logic        op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
  logic [31:0] src_a, src_b;
  logic        stall_e, busy;
  logic [31:0] hi_o, lo_o;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] hi_m, lo_m;

  muldiv_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn), .valid_e(valid_e),
    .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
    .op_mthi(op_mthi), .op_mtlo(op_mtlo), .src_a(src_a), .src_b(src_b),
    .stall_ext(stall_ext), .flush(flush),
    .stall_e(stall_e), .busy(busy), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // kinds: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO
  function automatic void model(input int kind, input logic [31:0] a, input logic [31:0] b);
    longint p, q, r;
    logic [63:0] u;
    case (kind)
      0: begin p = longint'($signed(a)) * longint'($signed(b)); {hi_m, lo_m} = p; end
      1: begin u = {32'd0, a} * {32'd0, b}; {hi_m, lo_m} = u; end
      2: if (b != 0) begin
           q = longint'($signed(a)) / longint'($signed(b));
           r = longint'($signed(a)) % longint'($signed(b));
           lo_m = q[31:0];
           hi_m = r[31:0];
         end
      3: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      4: hi_m = a;
      5: lo_m = a;
      default: ;
    endcase
  endfunction

  function automatic int exp_stalls(input int kind, input logic [31:0] b);
    if (kind < 2) return 1 + MUL_LAT;
    return (b == 0) ? 1 : 33;
  endfunction

  task automatic clr_ops();
    valid_e = 0; op_mult = 0; op_multu = 0; op_div = 0; op_divu = 0;
    op_mthi = 0; op_mtlo = 0;
  endtask

  task automatic set_op(input int kind, input logic [31:0] a, input logic [31:0] b);
    clr_ops();
    valid_e = 1; src_a = a; src_b = b;
    case (kind)
      0: op_mult = 1;
      1: op_multu = 1;
      2: op_div = 1;
      3: op_divu = 1;
      4: op_mthi = 1;
      default: op_mtlo = 1;
    endcase
  endtask

  // Entered and left just after a rising edge; returns after the commit edge.
  task automatic do_op(input int kind, input logic [31:0] a, input logic [31:0] b,
                       input bit clr, output int stalls, output bit ok);
    set_op(kind, a, b);
    stalls = 0; ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall_e) begin ok = 1; break; end
      stalls++;
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
      model(kind, a, b);
    end
    if (clr || !ok) clr_ops();
  endtask

  task automatic test_reset();
    resetn = 0; clr_ops(); stall_ext = 0; flush = 0; src_a = 0; src_b = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1; hi_m = 0; lo_m = 0;
    n_chk++; if (hi_o !== 32'h0) $display("FAIL reset_hi got %h exp 0", hi_o); else n_pass++;
    n_chk++; if (lo_o !== 32'h0) $display("FAIL reset_lo got %h exp 0", lo_o); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_chk++; if (stall_e !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall_e); else n_pass++;
  endtask

  task automatic run_one(input string nm, input int kind, input logic [31:0] a, input logic [31:0] b);
    int st; bit ok;
    do_op(kind, a, b, 1'b1, st, ok);
    n_chk++;
    if (!ok) $display("FAIL %s timeout waiting for DONE", nm);
    else if (st != exp_stalls(kind, b)) $display("FAIL %s stalls got %0d exp %0d", nm, st, exp_stalls(kind, b));
    else n_pass++;
    n_chk++;
    if (hi_o !== hi_m || lo_o !== lo_m)
      $display("FAIL %s a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h", nm, a, b, hi_o, lo_o, hi_m, lo_m);
    else n_pass++;
  endtask

  task automatic test_mult();
    run_one("mult_dir", 0, 32'hFFFFFFFE, 32'd3);
    n_chk++; if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFA)
      $display("FAIL mult_const got %h_%h exp ffffffff_fffffffa", hi_o, lo_o); else n_pass++;
    run_one("multu_dir", 1, 32'hFFFFFFFE, 32'd3);
    n_chk++; if (hi_o !== 32'h2 || lo_o !== 32'hFFFFFFFA)
      $display("FAIL multu_const got %h_%h exp 00000002_fffffffa", hi_o, lo_o); else n_pass++;
    for (int i = 0; i < 8; i++) run_one("mult_rnd", i % 2, $urandom, $urandom);
  endtask

  task automatic test_div();
    logic [31:0] b;
    run_one("div_dir", 2, 32'hFFFFFFF9, 32'd2);
    n_chk++; if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFD)
      $display("FAIL div_const got %h_%h exp ffffffff_fffffffd", hi_o, lo_o); else n_pass++;
    run_one("divu_dir", 3, 32'd100, 32'd7);
    run_one("div_ovf", 2, 32'h80000000, 32'hFFFFFFFF);
    n_chk++; if (hi_o !== 32'h0 || lo_o !== 32'h80000000)
      $display("FAIL div_ovf_const got %h_%h exp 00000000_80000000", hi_o, lo_o); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      b = (i < 4) ? ($urandom_range(1, 300) ^ ((i % 2 == 0) ? 32'hFFFFFF00 : 32'h0)) : $urandom;
      if (b == 0) b = 32'd5;
      run_one("div_rnd", 2 + (i % 2), $urandom, b);
    end
  endtask

  task automatic test_divzero();
    int st; bit ok;
    do_op(4, 32'h11, 0, 1'b1, st, ok);
    do_op(5, 32'h22, 0, 1'b1, st, ok);
    run_one("div_by0", 2, 32'h1234, 32'd0);
    n_chk++; if (hi_o !== 32'h11 || lo_o !== 32'h22)
      $display("FAIL div_by0_hold got %h_%h exp 00000011_00000022", hi_o, lo_o); else n_pass++;
  endtask

  task automatic test_flush();
    set_op(2, 32'd1000, 32'd7);
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1; #1;
    n_chk++; if (stall_e !== 1'b0) $display("FAIL flush_stall got %b exp 0", stall_e); else n_pass++;
    @(posedge clk); #1;
    flush = 0; clr_ops(); #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL flush_busy got %b exp 0", busy); else n_pass++;
    n_chk++; if (hi_o !== hi_m || lo_o !== lo_m)
      $display("FAIL flush_hilo got %h_%h exp %h_%h", hi_o, lo_o, hi_m, lo_m); else n_pass++;
    @(posedge clk); #1;
    run_one("divu_after_flush", 3, 32'd9, 32'd3);
  endtask

  task automatic test_stall_ext_mt();
    bit ok = 0;
    set_op(0, 32'h00012345, 32'hFFFF0003);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall_e) begin ok = 1; break; end
    end
    n_chk++; if (!ok) $display("FAIL stx timeout waiting for DONE"); else n_pass++;
    stall_ext = 1;
    repeat (3) begin
      @(posedge clk); #1;
      n_chk++; if (busy !== 1'b1 || stall_e !== 1'b0 || hi_o !== hi_m || lo_o !== lo_m)
        $display("FAIL stx_hold busy=%b stall=%b hilo=%h_%h exp busy=1 stall=0 hilo=%h_%h",
                 busy, stall_e, hi_o, lo_o, hi_m, lo_m);
      else n_pass++;
    end
    stall_ext = 0;
    @(posedge clk); #1;
    clr_ops(); model(0, 32'h00012345, 32'hFFFF0003);
    n_chk++; if (busy !== 1'b0 || hi_o !== hi_m || lo_o !== lo_m)
      $display("FAIL stx_commit busy=%b hilo=%h_%h exp busy=0 hilo=%h_%h", busy, hi_o, lo_o, hi_m, lo_m);
    else n_pass++;
    set_op(4, 32'hDEADBEEF, 0);
    @(posedge clk); #1; clr_ops();
    n_chk++; if (hi_o !== 32'hDEADBEEF) $display("FAIL mthi got %h exp deadbeef", hi_o); else n_pass++;
    set_op(4, 32'h12345678, 0); flush = 1;
    @(posedge clk); #1; clr_ops(); flush = 0;
    n_chk++; if (hi_o !== 32'hDEADBEEF) $display("FAIL mthi_flush got %h exp deadbeef", hi_o); else n_pass++;
    hi_m = 32'hDEADBEEF;
  endtask

  task automatic test_back_to_back();
    int st1, st2; bit ok1, ok2;
    logic [31:0] h1, l1;
    do_op(0, 32'd7, 32'hFFFFFFF0, 1'b0, st1, ok1);
    h1 = hi_m; l1 = lo_m;
    n_chk++; if (hi_o !== h1 || lo_o !== l1)
      $display("FAIL b2b_first got %h_%h exp %h_%h", hi_o, lo_o, h1, l1); else n_pass++;
    do_op(1, 32'hCAFEF00D, 32'h0BADBEEF, 1'b1, st2, ok2);
    n_chk++; if (!ok2 || st2 != 1 + MUL_LAT)
      $display("FAIL b2b_stalls got %0d exp %0d", st2, 1 + MUL_LAT); else n_pass++;
    n_chk++; if (hi_o !== hi_m || lo_o !== lo_m)
      $display("FAIL b2b_second got %h_%h exp %h_%h", hi_o, lo_o, hi_m, lo_m); else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    set_op(0, 32'h55555555, 32'h33333333);
    repeat (2) begin @(posedge clk); #1; end
    resetn = 0; clr_ops();
    @(posedge clk); #1;
    n_chk++; if (busy !== 1'b0 || stall_e !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0)
      $display("FAIL reset_mul busy=%b stall=%b hilo=%h_%h exp 0 0 0_0", busy, stall_e, hi_o, lo_o);
    else n_pass++;
    resetn = 1; hi_m = 0; lo_m = 0;
    @(posedge clk); #1;
    n_chk++; if (busy !== 1'b0 || hi_o !== 32'h0)
      $display("FAIL reset_mul_after busy=%b hi=%h exp 0 0", busy, hi_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_divzero();
    test_flush();
    test_stall_ext_mt();
    test_back_to_back();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
